fp_encode_seq: RTL and testbench
================================

Name: fp_encode_seq

Overview:
- Sequential, parametrised two's-complement-to-float encoder for the Lab 2 datapath.
- Takes an IN_W-bit signed sample and produces sign, EXP_W-bit exponent and SIG_W-bit significand, where value = sig * 2^exp.
- Normalises iteratively with one left shift per cycle, applies round-half-up, and saturates.
- Uses valid/ready handshakes on both sides so it can sit between a sample source and the display/FIFO stage.

Parameters:
- IN_W, 12, input width (signed two's complement); must exceed SIG_W+1.
- EXP_W, 3, exponent width; EMAX = 2^EXP_W-1.
- SIG_W, 4, significand width.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous active-high reset.
- in_data, input, IN_W, signed sample.
- in_valid, input, 1, sample offered.
- in_ready, output, 1, high only in IDLE.
- out_sign, output, 1, sign of result.
- out_exp, output, EXP_W, exponent.
- out_sig, output, SIG_W, significand.
- out_sat, output, 1, result was clamped to maximum magnitude.
- out_valid, output, 1, result held valid.
- out_ready, input, 1, consumer accepts result.

Behaviour:
- Reset (async, rst=1): state=IDLE; out_sign, out_exp, out_sig, out_sat and out_valid all 0; internal registers cleared. Reset mid-operation aborts the conversion and discards it. in_ready is 1 after reset releases.
- States: IDLE, NORM, ROUND, OUT.
- IDLE:
  - On in_valid & in_ready at a clock edge, capture sign = in_data[IN_W-1].
  - Capture mag = |in_data| as an unsigned IN_W-bit value. The most-negative input gives mag = 2^(IN_W-1).
  - Load cnt = IN_W-SIG_W. cnt is an internal register wide enough for IN_W-SIG_W+1 values.
  - Go to NORM.
- NORM, one decision per cycle:
  - If mag[IN_W-1]==1 or cnt==0, go to ROUND.
  - Else mag <= mag<<1 and cnt <= cnt-1.
  - k = the number of shifts taken, 0..IN_W-SIG_W.
- ROUND:
  - sig0 = mag[IN_W-1 -: SIG_W]; rb = mag[IN_W-1-SIG_W]; e = cnt.
  - If e > EMAX: saturate, giving exp = EMAX, sig = all ones, sat = 1.
  - Else if rb==1 and sig0 == all ones:
    - If e == EMAX: saturate.
    - Else sig = 1 followed by zeros (100..0), and exp = e+1.
  - Else if rb==1: sig = sig0+1, exp = e.
  - Else: sig = sig0, exp = e.
  - Register the outputs (out_sign = captured sign) and set out_valid = 1. Go to OUT.
- OUT:
  - Hold all outputs stable while out_ready==0.
  - On out_ready==1 at a clock edge, clear out_valid and go to IDLE.
  - Data outputs keep their last value until the next ROUND.
- Latency: out_valid rises k+2 edges after the accepting edge. Throughput is one sample per conversion; no overlap.
- in_valid is ignored outside IDLE, and in_data need not be held after acceptance.
- Zero input: sign 0, exp 0, sig 0, sat 0, k = IN_W-SIG_W.
- Sign is preserved on saturation.

Optional Feature:
- FP_ROUND_EN defined: round-half-up exactly as specified in ROUND, including mantissa-overflow renormalisation and saturation at EMAX.
- FP_ROUND_EN undefined: truncate. sig = sig0 and exp = e; saturation occurs only when e > EMAX.
- The ROUND state and latency are identical in both builds.

Test Plan (defaults IN_W=12, EXP_W=3, SIG_W=4, FP_ROUND_EN defined):
- in_data=12'd422, out_ready=1 -> sign 0, exp 5, sig 4'b1101, sat 0; out_valid 5 edges after acceptance (k=3).
- in_data=12'd124 -> rounding overflow: sig 4'b1000, exp 4, sat 0. Without FP_ROUND_EN -> sig 4'b1111, exp 3.
- in_data=12'h7FF -> sign 0, exp 7, sig 4'b1111, sat 1. in_data=12'h800 -> sign 1, exp 7, sig 4'b1111, sat 1 (k=0, latency 2).
- in_data=12'hFFB (-5) -> sign 1, exp 0, sig 4'b0101, sat 0; latency 10 edges. in_data=0 -> all zeros, latency 10.
- Backpressure: out_ready=0 for 6 cycles after out_valid -> outputs stable, in_ready=0, and an in_valid pulse is ignored. On out_ready=1, out_valid drops after that edge and in_ready=1 next cycle.
- Assert rst for 1 cycle in NORM during 12'd5 conversion -> outputs 0 and in_ready=1 immediately. A subsequent 12'd422 still yields exp 5, sig 4'b1101.

Source files
------------

// File: rtl/fp_encode_seq.sv
// rtl/fp_encode_seq.sv - sequential signed-to-float encoder, one normalising shift per cycle.
// FP_ROUND_EN selects round-half-up; without it the significand is truncated.
module fp_encode_seq #(
    parameter int IN_W  = 12,
    parameter int EXP_W = 3,
    parameter int SIG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_sign,
    output logic [EXP_W-1:0] out_exp,
    output logic [SIG_W-1:0] out_sig,
    output logic             out_sat,
    output logic             out_valid,
    input  logic             out_ready
);
    localparam int CNT_W = $clog2(IN_W - SIG_W + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(IN_W - SIG_W);
    localparam logic [31:0] EMAX = 32'((1 << EXP_W) - 1);

    typedef enum logic [1:0] {IDLE, NORM, ROUND, OUT} state_t;

    state_t            state_q, state_d;
    logic              sign_q, sign_d;
    logic [IN_W-1:0]   mag_q, mag_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              out_sign_q, out_sign_d;
    logic [EXP_W-1:0]  out_exp_q, out_exp_d;
    logic [SIG_W-1:0]  out_sig_q, out_sig_d;
    logic              out_sat_q, out_sat_d;
    logic              out_valid_q, out_valid_d;

    logic [SIG_W-1:0]  sig0;
    logic [31:0]       e;
`ifdef FP_ROUND_EN
    logic              rb;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sign_q      <= 1'b0;
            mag_q       <= '0;
            cnt_q       <= '0;
            out_sign_q  <= 1'b0;
            out_exp_q   <= '0;
            out_sig_q   <= '0;
            out_sat_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            mag_q       <= mag_d;
            cnt_q       <= cnt_d;
            out_sign_q  <= out_sign_d;
            out_exp_q   <= out_exp_d;
            out_sig_q   <= out_sig_d;
            out_sat_q   <= out_sat_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sign_d      = sign_q;
        mag_d       = mag_q;
        cnt_d       = cnt_q;
        out_sign_d  = out_sign_q;
        out_exp_d   = out_exp_q;
        out_sig_d   = out_sig_q;
        out_sat_d   = out_sat_q;
        out_valid_d = out_valid_q;

        sig0 = mag_q[IN_W-1 -: SIG_W];
        e    = 32'(cnt_q);
`ifdef FP_ROUND_EN
        rb   = mag_q[IN_W-1-SIG_W];
`endif

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d  = in_data[IN_W-1];
                    // The most-negative input negates to itself, which as unsigned is 2^(IN_W-1).
                    mag_d   = in_data[IN_W-1] ? IN_W'(-$signed(in_data)) : in_data;
                    cnt_d   = CNT_INIT;
                    state_d = NORM;
                end
            end
            NORM: begin
                if (mag_q[IN_W-1] || cnt_q == '0) begin
                    state_d = ROUND;
                end else begin
                    mag_d = mag_q << 1;
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ROUND: begin
                out_sign_d  = sign_q;
                out_sat_d   = 1'b0;
                out_sig_d   = sig0;
                out_exp_d   = EXP_W'(e);
                if (e > EMAX) begin
                    out_exp_d = '1;
                    out_sig_d = '1;
                    out_sat_d = 1'b1;
`ifdef FP_ROUND_EN
                end else if (rb && (&sig0)) begin
                    // Carry out of the significand renormalises into the exponent.
                    if (e == EMAX) begin
                        out_exp_d = '1;
                        out_sig_d = '1;
                        out_sat_d = 1'b1;
                    end else begin
                        out_sig_d = {1'b1, {(SIG_W-1){1'b0}}};
                        out_exp_d = EXP_W'(e + 32'd1);
                    end
                end else if (rb) begin
                    out_sig_d = sig0 + SIG_W'(1);
`endif
                end
                out_valid_d = 1'b1;
                state_d     = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_sign  = out_sign_q;
    assign out_exp   = out_exp_q;
    assign out_sig   = out_sig_q;
    assign out_sat   = out_sat_q;
    assign out_valid = out_valid_q;
endmodule

// File: tb/tb_fp_encode_seq.sv
// tb/tb_fp_encode_seq.sv - randomized and directed checks of fp_encode_seq against an arithmetic model.
module tb_fp_encode_seq;
    localparam int IN_W  = 12;
    localparam int EXP_W = 3;
    localparam int SIG_W = 4;
    localparam int EMAX  = (1 << EXP_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [IN_W-1:0]  in_data;
    logic             in_valid;
    logic             in_ready;
    logic             out_sign;
    logic [EXP_W-1:0] out_exp;
    logic [SIG_W-1:0] out_sig;
    logic             out_sat;
    logic             out_valid;
    logic             out_ready;

    int n_vec = 0;
    int n_bad = 0;

    fp_encode_seq #(.IN_W(IN_W), .EXP_W(EXP_W), .SIG_W(SIG_W)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_sign(out_sign), .out_exp(out_exp), .out_sig(out_sig), .out_sat(out_sat),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    // value = sig * 2^exp derived from the bit length of |x|.
    task automatic model(input logic [IN_W-1:0] d, output int s, output int ex, output int sg,
                         output int st, output int lat);
        int v, mag, blen, e, sig0, rb;
        v    = int'($signed(d));
        s    = (v < 0) ? 1 : 0;
        mag  = (v < 0) ? -v : v;
        blen = 0;
        while ((mag >> blen) != 0) blen++;
        e    = (blen > SIG_W) ? blen - SIG_W : 0;
        lat  = (IN_W - SIG_W - e) + 2;
        sig0 = mag >> e;
        rb   = (e > 0) ? ((mag >> (e - 1)) & 1) : 0;
`ifdef FP_ROUND_EN
        sg = sig0 + rb;
        ex = e;
        if (sg == (1 << SIG_W)) begin
            sg = 1 << (SIG_W - 1);
            ex = e + 1;
        end
`else
        sg = sig0;
        ex = e;
`endif
        st = 0;
        if (ex > EMAX) begin
            ex = EMAX;
            sg = (1 << SIG_W) - 1;
            st = 1;
        end
    endtask

    // Entered and left at #1 after a rising edge with the DUT idle.
    task automatic convert(input logic [IN_W-1:0] d, input int hold, input string tag);
        int s, ex, sg, st, lat, got_lat;
        model(d, s, ex, sg, st, lat);
        out_ready = (hold == 0);
        in_data   = d;
        in_valid  = 1'b1;
        check({tag, ".in_ready"}, int'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = IN_W'($urandom);
        got_lat  = 0;
        while (!out_valid && got_lat < 40) begin
            @(posedge clk); #1;
            got_lat++;
        end
        check({tag, ".latency"}, got_lat, lat);
        check({tag, ".sign"}, int'(out_sign), s);
        check({tag, ".exp"}, int'(out_exp), ex);
        check({tag, ".sig"}, int'(out_sig), sg);
        check({tag, ".sat"}, int'(out_sat), st);
        for (int i = 0; i < hold; i++) begin
            in_valid = i[0];
            in_data  = IN_W'($urandom);
            @(posedge clk); #1;
            check({tag, ".hold_valid"}, int'(out_valid), 1);
            check({tag, ".hold_ready"}, int'(in_ready), 0);
            check({tag, ".hold_data"}, int'({out_sign, out_exp, out_sig, out_sat}),
                  (s << (EXP_W + SIG_W + 1)) | (ex << (SIG_W + 1)) | (sg << 1) | st);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, ".drop_valid"}, int'(out_valid), 0);
        check({tag, ".back_idle"}, int'(in_ready), 1);
    endtask

    initial begin
        logic [IN_W-1:0] r;
        rst       = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst.valid", int'(out_valid), 0);
        check("rst.outs", int'({out_sign, out_exp, out_sig, out_sat}), 0);
        rst = 1'b0;
        #1;
        check("rst.in_ready", int'(in_ready), 1);
        @(posedge clk); #1;

        convert(12'd422, 0, "d422");
        convert(12'd124, 0, "d124");
        convert(12'h7FF, 0, "max_pos");
        convert(12'h800, 0, "max_neg");
        convert(12'hFFB, 0, "minus5");
        convert(12'd0,   0, "zero");
        convert(12'd422, 6, "backpressure");

        // Absolute anchors for the headline cases, independent of the model.
        convert(12'd124, 0, "anchor");
`ifdef FP_ROUND_EN
        check("anchor.exp124", int'(out_exp), 4);
        check("anchor.sig124", int'(out_sig), 8);
`else
        check("anchor.exp124", int'(out_exp), 3);
        check("anchor.sig124", int'(out_sig), 15);
`endif
        convert(12'h800, 0, "anchor2");
        check("anchor.neg_sat", int'({out_sign, out_exp, out_sig, out_sat}), 10'b1_111_1111_1);

        // Abort a conversion of 5 while it is normalising.
        in_data  = 12'd5;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("abort.in_ready", int'(in_ready), 1);
        check("abort.valid", int'(out_valid), 0);
        check("abort.outs", int'({out_sign, out_exp, out_sig, out_sat}), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        convert(12'd422, 0, "after_abort");
        check("after_abort.exp", int'(out_exp), 5);
        check("after_abort.sig", int'(out_sig), 13);

        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 3))
                0: r = IN_W'($urandom);
                1: r = IN_W'($urandom_range(0, 40));
                2: r = IN_W'(-$urandom_range(1, 40));
                default: r = IN_W'((1 << $urandom_range(0, IN_W - 1)) - $urandom_range(0, 2));
            endcase
            convert(r, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
